// File: rtl/io_port_pkg.sv
// Shared constants and helpers for the memory-mapped I/O port controller.
`timescale 1ns/1ps
package io_port_pkg;

    localparam int DATA_WIDTH = 32;

    typedef logic [2:0] reg_idx_t;

    localparam reg_idx_t REG_DATA    = 3'd0;
    localparam reg_idx_t REG_CFG     = 3'd1;
    localparam reg_idx_t REG_ENABLE  = 3'd2;
    localparam reg_idx_t REG_MASK    = 3'd3;
    localparam reg_idx_t REG_PENDING = 3'd4;
    localparam reg_idx_t REG_IRQ_ID  = 3'd5;

    // Bit 0 has the highest priority; returns 0 when nothing is set.
    function automatic logic [4:0] lowest_set_index(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Pin synchronizer plus tick-sampled debouncer with rising-edge detection.
`timescale 1ns/1ps
module io_debounce #(
    parameter int WIDTH      = 32,
    parameter int DEB_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] rise
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] samp;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] agree;
    logic [CW-1:0]    cnt;
    logic             tick;

    assign tick  = (cnt == LAST);
    assign agree = ~(sync2 ^ samp);
    assign rise  = stable & ~stable_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            samp     <= '0;
            stable   <= '0;
            stable_d <= '0;
            cnt      <= '0;
        end else begin
            sync1    <= pins;
            sync2    <= sync1;
            stable_d <= stable;
            cnt      <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                samp   <= sync2;
                // Only bits whose last two tick samples agree may move.
                stable <= (agree & sync2) | (~agree & stable);
            end
        end
    end

endmodule

// File: rtl/io_port_ctrl.sv
// Register file, pin drivers and prioritized interrupt for the 32-bit port_io.
`timescale 1ns/1ps
module io_port_ctrl #(
    parameter int DATA_WIDTH = io_port_pkg::DATA_WIDTH,
    parameter int DEB_CYCLES = 1000
) (
    input  logic                  sys_clk,
    input  logic                  rst_sync,
    input  logic                  ce,
    input  logic                  wr_en,
    input  logic [2:0]            addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  irq,
    output logic [4:0]            irq_id,
    inout  wire  [DATA_WIDTH-1:0] port_io
);

    import io_port_pkg::*;

    // Bus protocol: ce qualifies every access; ce&wr_en writes at the edge,
    // ce&~wr_en loads data_out at the edge (valid next cycle); no back-pressure.
    logic                  wr;
    logic                  rd;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [DATA_WIDTH-1:0] cfg_reg;
    logic [DATA_WIDTH-1:0] en_reg;
    logic [DATA_WIDTH-1:0] mask_reg;
    logic [DATA_WIDTH-1:0] pend_reg;
    logic [DATA_WIDTH-1:0] stable;
    logic [DATA_WIDTH-1:0] deb_rise;
    logic [DATA_WIDTH-1:0] rise;
    logic [DATA_WIDTH-1:0] clr;
    logic [DATA_WIDTH-1:0] active;
    logic [DATA_WIDTH-1:0] rd_mux;

    assign wr     = ce & wr_en;
    assign rd     = ce & ~wr_en;
    assign rise   = deb_rise & en_reg & cfg_reg;
    assign clr    = (wr && addr == REG_PENDING) ? data_in : '0;
    assign active = pend_reg & mask_reg;

    io_debounce #(
        .WIDTH      (DATA_WIDTH),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
        .clk    (sys_clk),
        .rst    (rst_sync),
        .pins   (port_io),
        .stable (stable),
        .rise   (deb_rise)
    );

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_pin
        assign port_io[i] = (en_reg[i] & ~cfg_reg[i]) ? data_reg[i] : 1'bz;
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            REG_DATA:    rd_mux = (en_reg & cfg_reg & stable) | (en_reg & ~cfg_reg & data_reg);
            REG_CFG:     rd_mux = cfg_reg;
            REG_ENABLE:  rd_mux = en_reg;
            REG_MASK:    rd_mux = mask_reg;
            REG_PENDING: rd_mux = pend_reg;
            REG_IRQ_ID:  rd_mux = {{(DATA_WIDTH-5){1'b0}}, irq_id};
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst_sync) begin
            data_reg <= '0;
            cfg_reg  <= '1;
            en_reg   <= '0;
            mask_reg <= '0;
            pend_reg <= '0;
            data_out <= '0;
            irq      <= 1'b0;
            irq_id   <= '0;
        end else begin
            if (wr) begin
                case (addr)
                    REG_DATA:   data_reg <= data_in;
                    REG_CFG:    cfg_reg  <= data_in;
                    REG_ENABLE: en_reg   <= data_in;
                    REG_MASK:   mask_reg <= data_in;
                    default:    ;
                endcase
            end
            // A new rise wins over a simultaneous write-1-to-clear.
            pend_reg <= (pend_reg & ~clr) | rise;
            irq      <= |active;
            irq_id   <= lowest_set_index(active);
            if (rd) data_out <= rd_mux;
        end
    end

endmodule

// File: doc/io_port_ctrl.md
Name: io_port_ctrl

Overview:
- Memory-mapped controller for the MIPS microcontroller's bidirectional 32-bit port_io.
- Sequences per-bit direction, output enable and output data, and synchronizes and debounces inputs such as the push-buttons on port_io[2:0].
- Detects rising edges on debounced inputs and raises a single prioritized interrupt to the core.
- Sits between the core's data bus (address-decoded chip select) and the top-level inout pins.

Parameters:
- DATA_WIDTH, 32, port width; 32 is the only supported value.
- DEB_CYCLES, 1000, sys_clk cycles between debounce samples; the bench overrides it to 4; minimum 2.

Ports:
- sys_clk  input  1  system clock; all logic on the rising edge
- rst_sync  input  1  synchronous, active-high reset
- ce  input  1  chip select from the core's address decoder
- wr_en  input  1  write strobe, qualified by ce
- addr  input  3  register word index
- data_in  input  32  write data
- data_out  output  32  registered read data
- irq  output  1  interrupt request, level
- irq_id  output  5  index of the highest-priority pending bit
- port_io  inout  32  external pins

Behaviour:
- Register map:
  - 0 DATA: read/write.
  - 1 CFG: 1 = input, 0 = output.
  - 2 ENABLE: 1 = bit active.
  - 3 MASK: interrupt mask.
  - 4 PENDING: write-1-to-clear.
  - 5 IRQ_ID: read-only.
  - Indices 6 and 7 read 0; writes to them are ignored.
- Reset values: DATA=0, CFG=all 1s, ENABLE=0, MASK=0, PENDING=0, debounce state=0, tick counter=0, data_out=0, irq=0, irq_id=0, all port_io bits Z.
- Pin drive: port_io[i] = data_reg[i] when ENABLE[i]=1 and CFG[i]=0, else Z. The pin changes on the cycle after the register write.
- Writes: when ce=1 and wr_en=1, the addressed register updates at the clock edge.
- Reads: when ce=1 and wr_en=0, data_out is loaded at that edge and is valid the following cycle (1-cycle latency). data_out holds its value while ce=0.
- DATA read value, per bit:
  - ENABLE=1 and CFG=1: stable[i].
  - ENABLE=1 and CFG=0: data_reg[i].
  - ENABLE=0: 0.
- Input path:
  - A 2-flop synchronizer on all 32 pins. A Z or X pin is treated as whatever the synchronizer captures; software must not enable undriven inputs.
  - A shared tick counter counts 0..DEB_CYCLES-1, pulses tick at the wrap, then restarts from 0.
  - On each tick: samp[i] <= sync[i]; stable[i] <= sync[i] only if sync[i]==samp[i] (two consecutive tick samples agree).
  - Glitches shorter than one tick period never reach stable.
- Edge detect: rise[i] = stable[i] & ~stable_d[i] & ENABLE[i] & CFG[i]. stable_d is stable delayed by one cycle.
- Pending:
  - PENDING[i] sets on rise[i], regardless of MASK.
  - A W1C write clears the bits written as 1.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- irq = |(PENDING & MASK), registered, so it asserts 1 cycle after PENDING updates.
- irq_id = lowest index i with PENDING[i] & MASK[i] (bit 0 has the highest priority), else 0. Registered together with irq.
- Writing CFG to 1 or ENABLE to 0 on a bit does not clear its PENDING bit.
- Reset mid-operation: every register, the synchronizer, the tick counter and the debounce state return to reset values on the next edge. Pins go to Z that same edge.

Decomposition:
- Package io_port_pkg holds:
  - register index constants: REG_DATA, REG_CFG, REG_ENABLE, REG_MASK, REG_PENDING, REG_IRQ_ID;
  - DATA_WIDTH;
  - a function lowest_set_index (32 bits to 5 bits).
- One sub-module: io_debounce. It contains the synchronizer, tick counter, samp/stable registers and rising-edge output, parameterized by width and DEB_CYCLES.

Test Plan:
- Reset then read every register -> DATA=0, CFG=0xFFFFFFFF, ENABLE=0, MASK=0, PENDING=0, IRQ_ID=0; port_io fully Z; irq=0.
- Write CFG=0xFFFFFFF8, ENABLE=0x7, DATA=0x5 -> port_io[2:0]=3'b101 one cycle after the DATA write; DATA readback=0x5; bits 31:3 remain Z.
- CFG=all 1s, ENABLE=0x7, MASK=0x7, DEB_CYCLES=4; drive port_io[2:0]=3'b100 and hold -> PENDING=0x4, irq=1, irq_id=2 within 3 ticks plus 4 cycles; a 2-cycle pulse on bit 1 leaves PENDING unchanged.
- Bits 2 and 1 pending with MASK=0x6 -> irq_id=1; W1C 0x2 -> irq_id=2; W1C 0x4 -> irq=0, irq_id=0.
- New rise on bit 0 in the same cycle as a W1C of 0x1 -> PENDING[0] stays 1 and irq stays asserted.
- Assert rst_sync while irq=1 and outputs are driven -> the next edge returns all registers to reset values, port_io goes Z and irq=0.
